tile_map_display: RTL and testbench

Parametrised VGA tile-map renderer replacing the fixed-layout game screen. Converts the VGA timing counters into a registered 8-bit RGB332 pixel from a writable COLS×ROWS tile map, a fixed 8-entry palette, a screen border, grid lines and a blinking cursor outline. It sits between the VGA sync generator and the DAC pins. Map updates arrive over a valid/ready port and are committed only during vertical blanking, so a frame never shows a partial update.

---
 rtl/tile_display_pkg.sv | 29 ++
 rtl/tile_write_buffer.sv | 60 ++++++
 rtl/tile_map_display.sv | 190 +++++++++++++++++++
 tb/tb_tile_map_display.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_display_pkg.sv
// Shared colour constants, palette lookup and tile-index type for the tile-map renderer.
package tile_display_pkg;

    typedef logic [2:0] tile_t;

    localparam logic [7:0] BLANK_RGB  = 8'b000_000_00;
    localparam logic [7:0] BORDER_RGB = 8'b111_111_11;
    localparam logic [7:0] GRID_RGB   = 8'b001_001_01;
    localparam logic [7:0] CURSOR_RGB = 8'b111_000_11;

    // Fixed 8-entry RGB332 palette.
    function automatic logic [7:0] palette_rgb(input tile_t idx);
        logic [7:0] c;
        c = BLANK_RGB;
        case (idx)
            3'd0: c = 8'b000_000_00;
            3'd1: c = 8'b111_000_00;
            3'd2: c = 8'b000_111_00;
            3'd3: c = 8'b100_100_10;
            3'd4: c = 8'b111_011_10;
            3'd5: c = 8'b111_111_00;
            3'd6: c = 8'b111_101_00;
            3'd7: c = 8'b000_000_11;
            default: c = BLANK_RGB;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tile_write_buffer.sv
// One-entry pending write register; releases its entry to the map only during vertical blanking.
module tile_write_buffer
    import tile_display_pkg::*;
#(
    parameter int unsigned COLS = 8,
    parameter int unsigned ROWS = 6,
    parameter int unsigned CW   = 3,
    parameter int unsigned RW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vblank,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [CW-1:0] wr_col,
    input  logic [RW-1:0] wr_row,
    input  tile_t         wr_tile,
    output logic          map_we,
    output logic [CW-1:0] map_col,
    output logic [RW-1:0] map_row,
    output tile_t         map_tile
);

    logic          pend_vld;
    logic [CW-1:0] pend_col;
    logic [RW-1:0] pend_row;
    tile_t         pend_tile;
    logic          commit;
    logic          accept;
    logic          in_range;

    assign commit   = pend_vld && in_vblank;
    assign wr_ready = !pend_vld || commit;
    assign accept   = wr_valid && wr_ready;
    assign in_range = (32'(pend_col) < COLS) && (32'(pend_row) < ROWS);

    // Out-of-range entries are retired like any other commit, just without a map write.
    assign map_we   = commit && in_range;
    assign map_col  = pend_col;
    assign map_row  = pend_row;
    assign map_tile = pend_tile;

    // Pending register: an accept reloads it even in the cycle its old entry commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_col  <= '0;
            pend_row  <= '0;
            pend_tile <= '0;
        end else if (accept) begin
            pend_vld  <= 1'b1;
            pend_col  <= wr_col;
            pend_row  <= wr_row;
            pend_tile <= wr_tile;
        end else if (commit) begin
            pend_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/tile_map_display.sv
// VGA tile-map renderer: two-stage pipeline from raw counters to a registered RGB332 pixel.
module tile_map_display
    import tile_display_pkg::*;
#(
    parameter int unsigned H_OFFSET     = 144,
    parameter int unsigned V_OFFSET     = 35,
    parameter int unsigned ACT_W        = 640,
    parameter int unsigned ACT_H        = 480,
    parameter int unsigned TILE_W       = 80,
    parameter int unsigned TILE_H       = 80,
    parameter int unsigned COLS         = 8,
    parameter int unsigned ROWS         = 6,
    parameter int unsigned BORDER       = 5,
    parameter int unsigned CUR_T        = 4,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              h_cnt,
    input  logic [9:0]              v_cnt,
    input  logic                    valid,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [2:0]              wr_tile,
    input  logic                    cur_en,
    input  logic [$clog2(COLS)-1:0] cur_col,
    input  logic [$clog2(ROWS)-1:0] cur_row,
    output logic                    frame_tick,
    output logic [7:0]              rgb
);

    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0] H_OFF      = 10'(H_OFFSET);
    localparam logic [9:0] V_OFF      = 10'(V_OFFSET);
    localparam logic [9:0] VB_START   = 10'(V_OFFSET + ACT_H);
    localparam logic [9:0] BRD        = 10'(BORDER);
    localparam logic [9:0] X_BRD_HI   = 10'(ACT_W - BORDER);
    localparam logic [9:0] Y_BRD_HI   = 10'(ACT_H - BORDER);
    localparam logic [9:0] TW         = 10'(TILE_W);
    localparam logic [9:0] TH         = 10'(TILE_H);
    localparam logic [9:0] CUR_LO     = 10'(CUR_T);
    localparam logic [9:0] CUR_X_HI   = 10'(TILE_W - CUR_T);
    localparam logic [9:0] CUR_Y_HI   = 10'(TILE_H - CUR_T);
    localparam logic [9:0] COLS_L     = 10'(COLS);
    localparam logic [9:0] ROWS_L     = 10'(ROWS);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

    // Tile map storage.
    tile_t map [ROWS][COLS];

    // Screen-space decode of the incoming counters.
    logic [9:0] x, y, col, row, px, py;
    logic       in_vblank;
    logic       border_hit, grid_hit, edge_hit, cursor_hit;

    // Blink / frame state.
    logic           in_vblank_q;
    logic           blink_on;
    logic [BCW-1:0] blink_cnt;

    // Stage-1 registers.
    logic       s1_valid, s1_border, s1_grid, s1_cursor;
    logic [9:0] s1_col, s1_row;

    // Stage-2 read and pixel selection.
    tile_t      map_rd;
    logic       s1_in_map;
    logic [7:0] pix_next;

    // Write path from the pending buffer.
    logic          map_we;
    logic [CW-1:0] map_col;
    logic [RW-1:0] map_row;
    tile_t         map_tile;

    assign in_vblank = (v_cnt < V_OFF) || (v_cnt >= VB_START);

    // Counter-to-tile decode and per-pixel hit flags for stage 1.
    always_comb begin
        x          = h_cnt - H_OFF;
        y          = v_cnt - V_OFF;
        col        = x / TW;
        px         = x % TW;
        row        = y / TH;
        py         = y % TH;
        border_hit = (x < BRD) || (x >= X_BRD_HI) || (y < BRD) || (y >= Y_BRD_HI);
        grid_hit   = (px == '0) || (py == '0);
        edge_hit   = (px < CUR_LO) || (px >= CUR_X_HI) || (py < CUR_LO) || (py >= CUR_Y_HI);
        cursor_hit = cur_en && blink_on && (col == 10'(cur_col)) && (row == 10'(cur_row)) && edge_hit;
    end

    tile_write_buffer #(
        .COLS (COLS),
        .ROWS (ROWS),
        .CW   (CW),
        .RW   (RW)
    ) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vblank (in_vblank),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_tile   (wr_tile),
        .map_we    (map_we),
        .map_col   (map_col),
        .map_row   (map_row),
        .map_tile  (map_tile)
    );

    // Map update; commits only arrive during vblank, so active pixels never see a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    map[r][c] <= '0;
                end
            end
        end else if (map_we) begin
            map[map_row][map_col] <= map_tile;
        end
    end

    // Stage 1: register the decoded flags and tile coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
            s1_grid   <= 1'b0;
            s1_cursor <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
        end else begin
            s1_valid  <= valid;
            s1_border <= border_hit;
            s1_grid   <= grid_hit;
            s1_cursor <= cursor_hit;
            s1_col    <= col;
            s1_row    <= row;
        end
    end

    assign s1_in_map = (s1_col < COLS_L) && (s1_row < ROWS_L);
    assign map_rd    = map[s1_row[RW-1:0]][s1_col[CW-1:0]];

    // Stage 2 pixel priority: blank, border, grid, cursor, off-map, tile colour.
    always_comb begin
        pix_next = BLANK_RGB;
        if (!s1_valid)      pix_next = BLANK_RGB;
        else if (s1_border) pix_next = BORDER_RGB;
        else if (s1_grid)   pix_next = GRID_RGB;
        else if (s1_cursor) pix_next = CURSOR_RGB;
        else if (!s1_in_map) pix_next = BLANK_RGB;
        else                pix_next = palette_rgb(map_rd);
    end

    // Stage 2 output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= '0;
        else        rgb <= pix_next;
    end

    // Vblank-entry pulse and cursor blink phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vblank_q <= 1'b0;
            frame_tick  <= 1'b0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
        end else begin
            in_vblank_q <= in_vblank;
            frame_tick  <= in_vblank && !in_vblank_q;
            if (frame_tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tile_map_display.sv
// Randomized and directed bench for tile_map_display against a frame-level reference model.
module tb_tile_map_display;

    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_cnt, v_cnt;
    logic       valid;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_col, wr_row, wr_tile;
    logic       cur_en;
    logic [2:0] cur_col, cur_row;
    logic       frame_tick;
    logic [7:0] rgb;

    always #5 clk = ~clk;

    tile_map_display #(.BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .valid      (valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_tile    (wr_tile),
        .cur_en     (cur_en),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .frame_tick (frame_tick),
        .rgb        (rgb)
    );

    // ---------------- reference model ----------------
    typedef struct { int c; int r; int t; } wr_t;

    int         m_map [6][8];
    wr_t        pend_q [$];
    logic [7:0] exp_q [$];
    int         ticks;
    bit         vb_prev, tick_now;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_vblank(input int v);
        return (v < 35) || (v >= 515);
    endfunction

    function automatic logic [7:0] pal(input int t);
        case (t)
            0: return 8'h00;
            1: return 8'hE0;
            2: return 8'h1C;
            3: return 8'h92;
            4: return 8'hEE;
            5: return 8'hFC;
            6: return 8'hF4;
            default: return 8'h03;
        endcase
    endfunction

    function automatic logic [7:0] ref_pixel();
        int x, y, col, row, px, py;
        bit blink;
        x = (int'(h_cnt) - 144 + 1024) % 1024;
        y = (int'(v_cnt) - 35 + 1024) % 1024;
        col = x / 80; px = x % 80;
        row = y / 80; py = y % 80;
        blink = ((ticks / BF) % 2) == 0;
        if (!valid) return 8'h00;
        if (x < 5 || x >= 635 || y < 5 || y >= 475) return 8'hFF;
        if (px == 0 || py == 0) return 8'h25;
        if (cur_en && blink && col == int'(cur_col) && row == int'(cur_row) &&
            (px < 4 || px >= 76 || py < 4 || py >= 76)) return 8'hE3;
        if (col >= 8 || row >= 6) return 8'h00;
        return pal(m_map[row][col]);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 8; c++)
                m_map[r][c] = 0;
        pend_q.delete();
        exp_q.delete();
        exp_q.push_back(8'h00);
        ticks    = 0;
        vb_prev  = 1'b0;
        tick_now = 1'b0;
    endtask

    task automatic model_edge();
        bit  vb, ready;
        wr_t w;
        if (tick_now) ticks++;
        vb       = is_vblank(int'(v_cnt));
        tick_now = vb && !vb_prev;
        vb_prev  = vb;
        ready    = (pend_q.size() == 0) || vb;
        if (pend_q.size() > 0 && vb) begin
            w = pend_q.pop_front();
            if (w.c < 8 && w.r < 6) m_map[w.r][w.c] = w.t;
        end
        if (wr_valid && ready) begin
            w.c = int'(wr_col); w.r = int'(wr_row); w.t = int'(wr_tile);
            pend_q.push_back(w);
        end
    endtask

    // One clock: inputs already driven after a negedge; checks ready, then rgb/frame_tick.
    task automatic cycle();
        bit exp_ready;
        #1;
        exp_ready = (pend_q.size() == 0) || is_vblank(int'(v_cnt));
        check("wr_ready", 10'(wr_ready), 10'(exp_ready));
        exp_q.push_back(rst_n ? ref_pixel() : 8'h00);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check("rgb", 10'(rgb), 10'(exp_q.pop_front()));
        check("frame_tick", 10'(frame_tick), 10'(tick_now));
    endtask

    task automatic set_px(input int x, input int y, input bit vld);
        h_cnt = 10'(x + 144);
        v_cnt = 10'(y + 35);
        valid = vld;
    endtask

    task automatic set_vb(input int v);
        h_cnt = 10'd0;
        v_cnt = 10'(v);
        valid = 1'b0;
    endtask

    task automatic pix_check(input string tag, input int x, input int y, input logic [7:0] exp);
        set_px(x, y, 1'b1);
        cycle();
        valid = 1'b0;
        cycle();
        check(tag, 10'(rgb), 10'(exp));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) cycle();
        check("rst_rgb", 10'(rgb), 10'h000);
        check("rst_ready", 10'(wr_ready), 10'h001);
        check("rst_tick", 10'(frame_tick), 10'h000);
        rst_n = 1'b1;
    endtask

    task automatic set_wr(input int c, input int r, input int t);
        wr_valid = 1'b1;
        wr_col = 3'(c); wr_row = 3'(r); wr_tile = 3'(t);
    endtask

    initial begin
        int tcount;
        rst_n = 1'b0; wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_tile = '0;
        cur_en = 1'b0; cur_col = '0; cur_row = '0;
        set_px(100, 100, 1'b1);
        model_reset();
        @(negedge clk);

        // Reset mid-frame, then a frame of blank tiles.
        do_reset(3);
        pix_check("blank_tile", 200, 100, 8'h00);
        pix_check("border_tl", 2, 2, 8'hFF);
        pix_check("border_r", 637, 300, 8'hFF);
        pix_check("grid", 80, 100, 8'h25);

        // Priority around the cursor.
        cur_en = 1'b1; cur_col = 3'd0; cur_row = 3'd0;
        pix_check("pri_border", 2, 2, 8'hFF);
        pix_check("pri_cursor", 6, 78, 8'hE3);
        cur_col = 3'd1; cur_row = 3'd1;
        pix_check("pri_grid", 80, 100, 8'h25);
        pix_check("pri_cursor2", 82, 100, 8'hE3);
        cur_en = 1'b0;

        // Write during vblank commits the next cycle.
        set_vb(520); set_wr(2, 1, 5);
        #1 check("vb_accept", 10'(wr_ready), 10'h001);
        cycle();
        wr_valid = 1'b0;
        cycle();
        pix_check("vb_write", 200, 100, 8'hFC);

        // Writes during active video wait for vblank.
        set_px(40, 100, 1'b1); set_wr(0, 4, 1);
        #1 check("act_accept", 10'(wr_ready), 10'h001);
        cycle();
        set_wr(1, 4, 2);
        #1 check("act_busy", 10'(wr_ready), 10'h000);
        cycle();
        pix_check("act_hold", 40, 360, 8'h00);
        set_vb(516);
        cycle();
        wr_valid = 1'b0;
        cycle();
        pix_check("act_commit", 40, 360, 8'hE0);
        pix_check("act_second", 120, 360, 8'h1C);

        // Out-of-range write is accepted and dropped.
        set_vb(520); set_wr(7, 7, 3);
        #1 check("oor_accept", 10'(wr_ready), 10'h001);
        cycle();
        wr_valid = 1'b0;
        cycle();
        cycle();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 8; c++) begin
                set_px(c * 80 + 40, r * 80 + 40, 1'b1);
                cycle();
            end
        pix_check("oor_tile", 600, 100, 8'h00);

        // Cursor blink over four frames.
        set_px(100, 100, 1'b1);
        do_reset(2);
        cur_en = 1'b1; cur_col = 3'd3; cur_row = 3'd2;
        for (int f = 0; f < 4; f++) begin
            pix_check($sformatf("blink_f%0d", f), 242, 200, (f < 2) ? 8'hE3 : 8'h00);
            tcount = 0;
            for (int i = 0; i < 4; i++) begin
                set_vb(515 + i);
                cycle();
                if (frame_tick) tcount++;
            end
            for (int i = 0; i < 3; i++) begin
                set_px(300, 300, 1'b0);
                cycle();
                if (frame_tick) tcount++;
            end
            check("tick_once", 10'(tcount), 10'h001);
        end

        // Randomized frames.
        for (int fr = 0; fr < 60; fr++) begin
            if (fr == 30) begin
                set_px(320, 240, 1'b1);
                do_reset(2);
            end
            cur_en  = 1'($urandom_range(0, 1));
            cur_col = 3'($urandom_range(0, 7));
            cur_row = 3'($urandom_range(0, 7));
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 5))
                    0, 1: set_px(int'(cur_col) * 80 + int'($urandom_range(0, 79)),
                                 int'(cur_row) * 80 + int'($urandom_range(0, 79)), 1'b1);
                    2:    begin h_cnt = 10'($urandom_range(0, 1023)); v_cnt = 10'($urandom_range(35, 514)); valid = 1'b1; end
                    default: set_px($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 9) != 0));
                endcase
                if (!wr_valid || $urandom_range(0, 3) == 0) begin
                    wr_valid = ($urandom_range(0, 3) == 0);
                    wr_col   = 3'($urandom_range(0, 7));
                    wr_row   = 3'($urandom_range(0, 7));
                    wr_tile  = 3'($urandom_range(0, 7));
                end
                cycle();
            end
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 1) == 0) set_vb($urandom_range(515, 524));
                else                           set_vb($urandom_range(0, 34));
                if ($urandom_range(0, 1) == 0) begin
                    wr_valid = 1'b1;
                    wr_col   = 3'($urandom_range(0, 7));
                    wr_row   = 3'($urandom_range(0, 7));
                    wr_tile  = 3'($urandom_range(0, 7));
                end else begin
                    wr_valid = 1'b0;
                end
                cycle();
            end
            wr_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
